// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the MEM stage: word/register widths, FSM encoding and
// the MEM/WB record, plus helpers to build bubbles and retirements.
package mem_stage_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic     valid;
    word_t    result;
    reg_idx_t rdest;
    logic     w_reg;
    logic     stop;
    word_t    pc;
  } wb_t;

  localparam logic     BUBBLE_VALID = 1'b0;
  localparam reg_idx_t BUBBLE_RDEST = '0;
  localparam logic     BUBBLE_W_REG = 1'b0;
  localparam logic     BUBBLE_STOP  = 1'b0;

  // A bubble keeps result and pc from the previous MEM/WB contents.
  function automatic wb_t make_bubble(input wb_t prev);
    wb_t b;
    b        = prev;
    b.valid  = BUBBLE_VALID;
    b.rdest  = BUBBLE_RDEST;
    b.w_reg  = BUBBLE_W_REG;
    b.stop   = BUBBLE_STOP;
    return b;
  endfunction

  function automatic wb_t make_retire(input word_t result, input reg_idx_t rdest,
                                      input logic w_reg, input logic stop,
                                      input word_t pc);
    wb_t r;
    r.valid  = 1'b1;
    r.result = result;
    r.rdest  = rdest;
    r.w_reg  = w_reg;
    r.stop   = stop;
    r.pc     = pc;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM stage controller and the memory.
interface mem_stage_ctrl_if;
  import mem_stage_ctrl_pkg::*;

  logic  req;
  logic  we;
  word_t addr;
  word_t wdata;
  word_t rdata;
  logic  ack;

  modport master (output req, output we, output addr, output wdata,
                  input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata,
                  output rdata, output ack);
endinterface

// File: rtl/mem_stage_ctrl_timeout_ctr.sv
// Saturating WAIT-cycle counter with the watchdog limit comparator.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear)
      cnt_next = '0;
    else if (en && (cnt_reg != {CNT_W{1'b1}}))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  // A TIMEOUT of zero disables the watchdog entirely.
  assign at_limit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: retires EX/MEM instructions, running loads/stores over a
// variable-latency req/ack memory with a timeout watchdog.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     in_valid,
  input  word_t    in_M_addr,
  input  word_t    in_ANS_LHI_PC1,
  input  word_t    in_Data_in,
  input  reg_idx_t in_RDest,
  input  logic     in_mem_ans,
  input  logic     in_W_mem,
  input  logic     in_W_reg,
  input  logic     in_stop,
  input  word_t    in_pc,
  output logic     stall_EX,
  mem_stage_ctrl_if.master mem,
  output logic     out_valid,
  output word_t    out_result,
  output reg_idx_t out_RDest,
  output logic     out_W_reg,
  output logic     out_stop,
  output word_t    out_pc,
  output logic     mem_err
);

  state_t state_reg, state_next;
  wb_t    wb_reg, wb_next;
  logic   req_reg, req_next;
  logic   we_reg, we_next;
  word_t  addr_reg, addr_next;
  word_t  wdata_reg, wdata_next;
  logic   err_reg, err_next;

  logic memop, is_load, at_limit, timeout_hit, cnt_clear, cnt_en;

  assign memop   = in_valid & (in_W_mem | in_mem_ans);
  // A store that also flags mem_ans still writes back the ALU result.
  assign is_load = in_mem_ans & ~in_W_mem;

  assign timeout_hit = (state_reg == WAIT) & at_limit & ~mem.ack;
  assign cnt_clear   = (state_reg == IDLE) & memop;
  assign cnt_en      = (state_reg == WAIT) & ~mem.ack & ~timeout_hit;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (cnt_clear),
    .en       (cnt_en),
    .at_limit (at_limit)
  );

  always_comb begin
    state_next = state_reg;
    wb_next    = wb_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    err_next   = err_reg;
    stall_EX   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!in_valid) begin
          wb_next = make_bubble(wb_reg);
        end else if (memop) begin
          stall_EX   = 1'b1;
          wb_next    = make_bubble(wb_reg);
          req_next   = 1'b1;
          we_next    = in_W_mem;
          addr_next  = in_M_addr;
          wdata_next = in_Data_in;
          state_next = WAIT;
        end else begin
          wb_next = make_retire(in_ANS_LHI_PC1, in_RDest, in_W_reg, in_stop, in_pc);
        end
      end
      WAIT: begin
        // Ack beats the watchdog when both land on the same edge.
        if (mem.ack) begin
          wb_next    = make_retire(is_load ? mem.rdata : in_ANS_LHI_PC1,
                                   in_RDest, in_W_reg, in_stop, in_pc);
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (timeout_hit) begin
          wb_next    = make_retire(in_ANS_LHI_PC1, in_RDest, 1'b0, in_stop, in_pc);
          err_next   = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else begin
          stall_EX = 1'b1;
          wb_next  = make_bubble(wb_reg);
        end
      end
    endcase
  end

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      wb_reg    <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wb_reg    <= wb_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
    end
  end

  assign mem.req    = req_reg;
  assign mem.we     = we_reg;
  assign mem.addr   = addr_reg;
  assign mem.wdata  = wdata_reg;

  assign out_valid  = wb_reg.valid;
  assign out_result = wb_reg.result;
  assign out_RDest  = wb_reg.rdest;
  assign out_W_reg  = wb_reg.w_reg;
  assign out_stop   = wb_reg.stop;
  assign out_pc     = wb_reg.pc;
  assign mem_err    = err_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: each issued instruction pushes its
// expected MEM/WB record; the monitor pops and compares on every retirement.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int TO = 6;

  logic     clk = 1'b0;
  logic     resetn;
  logic     in_valid, in_mem_ans, in_W_mem, in_W_reg, in_stop;
  word_t    in_M_addr, in_ANS_LHI_PC1, in_Data_in, in_pc;
  reg_idx_t in_RDest;
  logic     stall_EX;
  logic     out_valid, out_W_reg, out_stop, mem_err;
  word_t    out_result, out_pc;
  reg_idx_t out_RDest;

  mem_stage_ctrl_if mem_if();

  mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_M_addr      (in_M_addr),
    .in_ANS_LHI_PC1 (in_ANS_LHI_PC1),
    .in_Data_in     (in_Data_in),
    .in_RDest       (in_RDest),
    .in_mem_ans     (in_mem_ans),
    .in_W_mem       (in_W_mem),
    .in_W_reg       (in_W_reg),
    .in_stop        (in_stop),
    .in_pc          (in_pc),
    .stall_EX       (stall_EX),
    .mem            (mem_if.master),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .out_RDest      (out_RDest),
    .out_W_reg      (out_W_reg),
    .out_stop       (out_stop),
    .out_pc         (out_pc),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t    result;
    reg_idx_t rdest;
    logic     w_reg;
    logic     stop;
    word_t    pc;
    bit       tmo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Retirement monitor: outputs settle just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_retire", out_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("ret_stop", out_stop, mon_e.stop);
        check("ret_w_reg", out_W_reg, mon_e.w_reg);
        if (!mon_e.tmo) begin
          check("ret_result", out_result, mon_e.result);
          check("ret_rdest", out_RDest, mon_e.rdest);
          check("ret_pc", out_pc, mon_e.pc);
        end
        $display("retire pc=%h result=%h rd=%0d w_reg=%0b stop=%0b err=%0b",
                 out_pc, out_result, out_RDest, out_W_reg, out_stop, mem_err);
      end
    end
  end

  // ack_at = k acks in the k-th WAIT cycle; 0 means never (watchdog fires).
  task automatic issue(input logic v, input logic wm, input logic ma,
                       input word_t addr, input word_t ans, input word_t data,
                       input reg_idx_t rd, input logic wr, input logic st,
                       input word_t pc, input int ack_at, input word_t rdata,
                       input string name);
    exp_t e;
    int   stalls = 0;
    int   k = 0;
    bit   done = 0;
    bit   memop;
    memop          = v && (wm || ma);
    in_valid       = v;
    in_W_mem       = wm;
    in_mem_ans     = ma;
    in_M_addr      = addr;
    in_ANS_LHI_PC1 = ans;
    in_Data_in     = data;
    in_RDest       = rd;
    in_W_reg       = wr;
    in_stop        = st;
    in_pc          = pc;
    if (v) begin
      e.tmo    = memop && (ack_at == 0);
      e.stop   = st;
      e.w_reg  = e.tmo ? 1'b0 : wr;
      e.rdest  = rd;
      e.pc     = pc;
      e.result = (ma && !wm) ? rdata : ans;
      sb_q.push_back(e);
    end
    while (!done) begin
      if (memop && k > 0 && k == ack_at) begin
        mem_if.ack   = 1'b1;
        mem_if.rdata = rdata;
      end
      @(posedge clk);
      if (stall_EX) stalls++;
      if (memop && k > 0) begin
        check({name, "_req"}, mem_if.req, 1);
        check({name, "_addr"}, mem_if.addr, addr);
        check({name, "_we"}, mem_if.we, wm);
        check({name, "_wdata"}, mem_if.wdata, data);
      end
      done = !stall_EX;
      @(negedge clk);
      #1;
      mem_if.ack   = 1'b0;
      mem_if.rdata = 16'hDEAD;
      k++;
      if (!done) check({name, "_bubble"}, out_valid, 0);
      if (k > 50) begin
        check({name, "_hang_cycles"}, k, 0);
        done = 1;
      end
    end
    check({name, "_stall_cycles"}, stalls, memop ? ((ack_at == 0) ? TO : ack_at) : 0);
    check({name, "_req_off"}, mem_if.req, 0);
    if (!v) begin
      check({name, "_valid"}, out_valid, 0);
      check({name, "_rdest"}, out_RDest, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    resetn         = 1'b0;
    in_valid       = 1'b0;
    in_mem_ans     = 1'b0;
    in_W_mem       = 1'b0;
    in_W_reg       = 1'b0;
    in_stop        = 1'b0;
    in_M_addr      = '0;
    in_ANS_LHI_PC1 = '0;
    in_Data_in     = '0;
    in_RDest       = '0;
    in_pc          = '0;
    mem_if.ack     = 1'b0;
    mem_if.rdata   = '0;
    #12;
    check("rst_req", mem_if.req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_pc", out_pc, 0);
    check("rst_err", mem_err, 0);
    check("rst_addr", mem_if.addr, 0);
    @(posedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;

    //     v  wm ma addr      ans       data      rd wr st pc        ack rdata
    issue(1, 0, 0, 16'h0000, 16'h1234, 16'h0000, 3, 1, 0, 16'h0100, 0, 16'h0000, "alu");
    issue(1, 0, 1, 16'h0040, 16'h7777, 16'h0000, 5, 1, 0, 16'h0101, 1, 16'hBEEF, "load");
    issue(1, 1, 1, 16'h0010, 16'h5555, 16'hA5A5, 2, 0, 0, 16'h0102, 5, 16'h3C3C, "store");
    issue(0, 0, 0, 16'h0000, 16'h9999, 16'h0000, 6, 1, 1, 16'h0103, 0, 16'h0000, "idle");
    issue(1, 0, 1, 16'h0022, 16'h1111, 16'h0000, 4, 1, 0, 16'h0104, TO, 16'hCAFE, "ack_at_limit");
    check("err_after_limit_ack", mem_err, 0);
    issue(1, 0, 1, 16'h0033, 16'h2222, 16'h0000, 1, 1, 1, 16'h0105, 0, 16'h0000, "timeout");
    check("err_set", mem_err, 1);
    issue(1, 0, 0, 16'h0000, 16'h4321, 16'h0000, 7, 1, 0, 16'h0106, 0, 16'h0000, "alu2");
    check("err_sticky", mem_err, 1);

    // Reset while an access is outstanding; a late ack must not retire anything.
    in_valid   = 1'b1;
    in_mem_ans = 1'b1;
    in_W_mem   = 1'b0;
    in_M_addr  = 16'h0080;
    @(negedge clk);
    #1;
    check("rstwait_req_before", mem_if.req, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("rstwait_req", mem_if.req, 0);
    check("rstwait_valid", out_valid, 0);
    check("rstwait_err", mem_err, 0);
    check("rstwait_addr", mem_if.addr, 0);
    check("rstwait_pc", out_pc, 0);
    in_valid = 1'b0;
    @(posedge clk);
    resetn       = 1'b1;
    mem_if.ack   = 1'b1;
    mem_if.rdata = 16'hF00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("late_ack_valid", out_valid, 0);
      check("late_ack_req", mem_if.req, 0);
    end
    mem_if.ack = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("sb_left", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
